// File: rtl/fetch_exec_controller.sv
// Program-counter-driven instruction sequencer: fetches from a synchronous memory,
// owns PC and the data-address register, and steps the datapath through each instruction.
module fetch_exec_controller #(
    parameter int          PC_W   = 9,
    parameter int unsigned RST_PC = 0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [2:0]      opcode,
    input  logic [1:0]      op,
    input  logic [15:0]     datapath_out,
    output logic [1:0]      mem_cmd,
    output logic [PC_W-1:0] mem_addr,
    output logic [PC_W-1:0] pc,
    output logic            load_ir,
    output logic [1:0]      nsel,
    output logic            loada,
    output logic            loadb,
    output logic            loadc,
    output logic            loads,
    output logic            asel,
    output logic            bsel,
    output logic            write,
    output logic [1:0]      vsel,
    output logic            halted,
    output logic            illegal
);

    // state | meaning
    // RST   | reset, all controls idle
    // IF1   | present PC to memory
    // IF2   | instruction word valid, load IR
    // UPC   | PC <= PC + 1
    // DEC   | dispatch on {opcode, op}
    // GETA  | A <= Rn
    // GETB  | B <= Rm
    // ALU   | C <= A op B
    // CMP   | status <= A - B
    // MOVB  | C <= 0 + B
    // WREG  | Rd <= C
    // WIMM  | Rn <= sximm8
    // ADDR  | C <= A + sximm5
    // LDA   | data_addr <= C
    // LDM   | present data_addr for read
    // LDW   | Rd <= mdata
    // STB   | B <= Rd
    // STC   | C <= 0 + B
    // STM   | write C to memory at data_addr
    // HALT  | stopped until reset
    // TRAP  | illegal encoding, stopped until reset

    typedef enum logic [4:0] {
        S_RST, S_IF1, S_IF2, S_UPC, S_DEC, S_GETA, S_GETB, S_ALU, S_CMP, S_MOVB,
        S_WREG, S_WIMM, S_ADDR, S_LDA, S_LDM, S_LDW, S_STB, S_STC, S_STM,
        S_HALT, S_TRAP
    } state_t;

    localparam logic [1:0] CMD_NONE  = 2'b00;
    localparam logic [1:0] CMD_READ  = 2'b01;
    localparam logic [1:0] CMD_WRITE = 2'b10;

    localparam logic [1:0] NSEL_RM = 2'b00;
    localparam logic [1:0] NSEL_RD = 2'b01;
    localparam logic [1:0] NSEL_RN = 2'b10;

    localparam logic [1:0] VSEL_C     = 2'b00;
    localparam logic [1:0] VSEL_IMM   = 2'b10;
    localparam logic [1:0] VSEL_MDATA = 2'b11;

    localparam logic [PC_W-1:0] RST_PC_V = PC_W'(RST_PC);

    state_t          state;
    state_t          state_next;
    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] data_addr;

    logic is_movi;
    logic is_mov;
    logic is_alu;
    logic is_ldr;
    logic is_str;
    logic is_halt;

    // Only the low PC_W bits of the datapath result form an address.
    logic unused_dp_hi;
    assign unused_dp_hi = ^datapath_out[15:PC_W];

    assign is_movi = ({opcode, op} == 5'b110_10);
    assign is_mov  = ({opcode, op} == 5'b110_00);
    assign is_alu  = (opcode == 3'b101);
    assign is_ldr  = ({opcode, op} == 5'b011_00);
    assign is_str  = ({opcode, op} == 5'b100_00);
    assign is_halt = ({opcode, op} == 5'b111_00);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_RST;
            pc_q      <= RST_PC_V;
            data_addr <= '0;
        end else begin
            state <= state_next;
            if (state == S_UPC) begin
                pc_q <= pc_q + PC_W'(1);
            end
            if (state == S_LDA) begin
                data_addr <= datapath_out[PC_W-1:0];
            end
        end
    end

    assign pc = pc_q;

    always_comb begin
        state_next = state;
        mem_cmd    = CMD_NONE;
        mem_addr   = '0;
        load_ir    = 1'b0;
        nsel       = NSEL_RM;
        vsel       = VSEL_C;
        loada      = 1'b0;
        loadb      = 1'b0;
        loadc      = 1'b0;
        loads      = 1'b0;
        asel       = 1'b0;
        bsel       = 1'b0;
        write      = 1'b0;
        halted     = 1'b0;
        illegal    = 1'b0;

        case (state)
            S_RST: begin
                state_next = S_IF1;
            end
            S_IF1: begin
                mem_cmd    = CMD_READ;
                mem_addr   = pc_q;
                state_next = S_IF2;
            end
            S_IF2: begin
                mem_cmd    = CMD_READ;
                mem_addr   = pc_q;
                load_ir    = 1'b1;
                state_next = S_UPC;
            end
            S_UPC: begin
                state_next = S_DEC;
            end
            S_DEC: begin
                if (is_movi) begin
                    state_next = S_WIMM;
                end else if (is_mov) begin
                    state_next = S_GETB;
                end else if (is_alu) begin
                    // MVN only needs the B operand.
                    state_next = (op == 2'b11) ? S_GETB : S_GETA;
                end else if (is_ldr || is_str) begin
                    state_next = S_GETA;
                end else if (is_halt) begin
                    state_next = S_HALT;
                end else begin
                    state_next = S_TRAP;
                end
            end
            S_GETA: begin
                nsel       = NSEL_RN;
                loada      = 1'b1;
                state_next = (is_ldr || is_str) ? S_ADDR : S_GETB;
            end
            S_GETB: begin
                nsel  = NSEL_RM;
                loadb = 1'b1;
                if (is_mov) begin
                    state_next = S_MOVB;
                end else if (op == 2'b01) begin
                    state_next = S_CMP;
                end else begin
                    state_next = S_ALU;
                end
            end
            S_ALU: begin
                loadc      = 1'b1;
                state_next = S_WREG;
            end
            S_CMP: begin
                loads      = 1'b1;
                state_next = S_IF1;
            end
            S_MOVB: begin
                asel       = 1'b1;
                loadc      = 1'b1;
                state_next = S_WREG;
            end
            S_WREG: begin
                nsel       = NSEL_RD;
                vsel       = VSEL_C;
                write      = 1'b1;
                state_next = S_IF1;
            end
            S_WIMM: begin
                nsel       = NSEL_RN;
                vsel       = VSEL_IMM;
                write      = 1'b1;
                state_next = S_IF1;
            end
            S_ADDR: begin
                bsel       = 1'b1;
                loadc      = 1'b1;
                state_next = S_LDA;
            end
            S_LDA: begin
                state_next = is_str ? S_STB : S_LDM;
            end
            S_LDM: begin
                mem_cmd    = CMD_READ;
                mem_addr   = data_addr;
                state_next = S_LDW;
            end
            S_LDW: begin
                // Address held from LDM so the read data stays valid while it is written back.
                mem_cmd    = CMD_READ;
                mem_addr   = data_addr;
                nsel       = NSEL_RD;
                vsel       = VSEL_MDATA;
                write      = 1'b1;
                state_next = S_IF1;
            end
            S_STB: begin
                nsel       = NSEL_RD;
                loadb      = 1'b1;
                state_next = S_STC;
            end
            S_STC: begin
                asel       = 1'b1;
                loadc      = 1'b1;
                state_next = S_STM;
            end
            S_STM: begin
                mem_cmd    = CMD_WRITE;
                mem_addr   = data_addr;
                state_next = S_IF1;
            end
            S_HALT: begin
                halted     = 1'b1;
                state_next = S_HALT;
            end
            S_TRAP: begin
                halted     = 1'b1;
                illegal    = 1'b1;
                state_next = S_TRAP;
            end
            default: begin
                state_next = S_TRAP;
            end
        endcase
    end

endmodule

// File: tb/tb_fetch_exec_controller.sv
// Bench: controller driving a behavioural datapath and memory; an ISA-level model
// predicts fetches, register writes, memory writes and per-instruction cycle counts.
module tb_fetch_exec_controller;

    localparam int PC_W = 9;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            reset;
    logic [2:0]      opcode;
    logic [1:0]      op;
    logic [15:0]     datapath_out;
    logic [1:0]      mem_cmd;
    logic [PC_W-1:0] mem_addr;
    logic [PC_W-1:0] pc;
    logic            load_ir;
    logic [1:0]      nsel;
    logic            loada, loadb, loadc, loads, asel, bsel, write;
    logic [1:0]      vsel;
    logic            halted, illegal;

    fetch_exec_controller #(.PC_W(9), .RST_PC(0)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .op(op), .datapath_out(datapath_out),
        .mem_cmd(mem_cmd), .mem_addr(mem_addr), .pc(pc), .load_ir(load_ir), .nsel(nsel),
        .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads), .asel(asel),
        .bsel(bsel), .write(write), .vsel(vsel), .halted(halted), .illegal(illegal)
    );

    // Second instance for the narrow-PC wrap and address truncation cases.
    logic        b_reset;
    logic [2:0]  b_opcode;
    logic [1:0]  b_op;
    logic [15:0] b_datapath_out;
    logic [1:0]  b_mem_cmd;
    logic [3:0]  b_mem_addr;
    logic [3:0]  b_pc;
    logic        b_load_ir;
    logic [1:0]  b_nsel;
    logic        b_loada, b_loadb, b_loadc, b_loads, b_asel, b_bsel, b_write;
    logic [1:0]  b_vsel;
    logic        b_halted, b_illegal;

    fetch_exec_controller #(.PC_W(4), .RST_PC(15)) dut_b (
        .clk(clk), .reset(b_reset), .opcode(b_opcode), .op(b_op), .datapath_out(b_datapath_out),
        .mem_cmd(b_mem_cmd), .mem_addr(b_mem_addr), .pc(b_pc), .load_ir(b_load_ir), .nsel(b_nsel),
        .loada(b_loada), .loadb(b_loadb), .loadc(b_loadc), .loads(b_loads), .asel(b_asel),
        .bsel(b_bsel), .write(b_write), .vsel(b_vsel), .halted(b_halted), .illegal(b_illegal)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_evt(input string name);
        tests++;
        fails++;
        $display("FAIL %s: event occurred, none expected", name);
    endtask

    // ---------------- behavioural datapath and memory ----------------
    logic [15:0] img_mem [0:511];
    logic [15:0] img_rf  [0:7];
    logic        do_load;

    logic [15:0] mem [0:511];
    logic [15:0] rf  [0:7];
    logic [15:0] ir, ra, rb, rc, mdata;
    logic [2:0]  rsel;
    logic [15:0] a_in, b_in, alu_out, wr_val;

    assign opcode       = ir[15:13];
    assign op           = ir[12:11];
    assign datapath_out = rc;
    assign rsel    = (nsel == 2'b00) ? ir[2:0] : (nsel == 2'b01) ? ir[7:5] : ir[10:8];
    assign a_in    = asel ? 16'h0000 : ra;
    assign b_in    = bsel ? {{11{ir[4]}}, ir[4:0]} : rb;
    assign alu_out = (ir[12:11] == 2'b00) ? a_in + b_in :
                     (ir[12:11] == 2'b01) ? a_in - b_in :
                     (ir[12:11] == 2'b10) ? (a_in & b_in) : ~b_in;
    assign wr_val  = (vsel == 2'b00) ? rc :
                     (vsel == 2'b01) ? {7'b0, pc} :
                     (vsel == 2'b10) ? {{8{ir[7]}}, ir[7:0]} : mdata;

    always @(posedge clk) begin
        if (do_load) begin
            for (int k = 0; k < 512; k++) mem[k] <= img_mem[k];
            for (int k = 0; k < 8; k++) rf[k] <= img_rf[k];
            ir    <= '0;
            ra    <= '0;
            rb    <= '0;
            rc    <= '0;
            mdata <= '0;
        end else begin
            mdata <= (mem_cmd == 2'b01) ? mem[mem_addr] : 16'hDEAD;
            if (mem_cmd == 2'b10) mem[mem_addr] <= rc;
            if (load_ir) ir <= mdata;
            if (loada) ra <= rf[rsel];
            if (loadb) rb <= rf[rsel];
            if (loadc) rc <= alu_out;
            if (write) rf[rsel] <= wr_val;
        end
    end

    logic [24:0] ctrl_vec;
    assign ctrl_vec = {mem_cmd, mem_addr, load_ir, nsel, loada, loadb, loadc, loads,
                       asel, bsel, write, vsel, halted, illegal};

    // Boundary instance environment: fixed datapath result, tiny memory.
    logic [15:0] b_mem [0:15];
    logic [15:0] b_mdata, b_ir;
    assign b_opcode       = b_ir[15:13];
    assign b_op           = b_ir[12:11];
    assign b_datapath_out = 16'h01F3;
    always @(posedge clk) begin
        b_mdata <= (b_mem_cmd == 2'b01) ? b_mem[b_mem_addr] : 16'hDEAD;
        if (b_load_ir) b_ir <= b_mdata;
    end

    // ---------------- encoders ----------------
    function automatic logic [15:0] e_movi(input int rn, input int imm);
        return {3'b110, 2'b10, 3'(rn), 8'(imm)};
    endfunction
    function automatic logic [15:0] e_mov(input int rd, input int rm);
        return {3'b110, 2'b00, 3'b000, 3'(rd), 2'b00, 3'(rm)};
    endfunction
    function automatic logic [15:0] e_alu(input int aop, input int rd, input int rn, input int rm);
        return {3'b101, 2'(aop), 3'(rn), 3'(rd), 2'b00, 3'(rm)};
    endfunction
    function automatic logic [15:0] e_ldr(input int rd, input int rn, input int imm);
        return {3'b011, 2'b00, 3'(rn), 3'(rd), 5'(imm)};
    endfunction
    function automatic logic [15:0] e_str(input int rd, input int rn, input int imm);
        return {3'b100, 2'b00, 3'(rn), 3'(rd), 5'(imm)};
    endfunction
    function automatic bit is_legal(input logic [4:0] code);
        return (code == 5'b11010) || (code == 5'b11000) || (code[4:2] == 3'b101) ||
               (code == 5'b01100) || (code == 5'b10000) || (code == 5'b11100);
    endfunction

    // ---------------- scoreboard ----------------
    logic [8:0]  exp_fetch [$];
    int          exp_cyc   [$];
    logic [18:0] exp_wr    [$];
    logic [24:0] exp_mw    [$];
    // counters: 0 loada, 1 loadb, 2 loadc, 3 loads, 4 asel, 5 bsel, 6 read cycles, 7 load_ir
    int exp_cnt [8];
    int act_cnt [8];
    bit mon_en;
    int cyc_cnt;
    int last_fetch;

    // ISA-level execution of the loaded image, straight-line until HALT or an illegal word.
    task automatic build_model(output logic exp_ill, output logic [8:0] exp_pc);
        logic [15:0] m [512];
        logic [15:0] r [8];
        logic [8:0]  p, ea;
        logic [15:0] i, v;
        logic [2:0]  rn, rd, rm;
        bit          done;
        for (int k = 0; k < 512; k++) m[k] = img_mem[k];
        for (int k = 0; k < 8; k++) r[k] = img_rf[k];
        exp_fetch.delete();
        exp_cyc.delete();
        exp_wr.delete();
        exp_mw.delete();
        for (int k = 0; k < 8; k++) exp_cnt[k] = 0;
        p = '0;
        done = 0;
        exp_ill = 1'b0;
        for (int n = 0; n < 400 && !done; n++) begin
            i = m[p];
            exp_fetch.push_back(p);
            p = p + 9'd1;
            exp_cnt[6] += 2;
            exp_cnt[7] += 1;
            rn = i[10:8];
            rd = i[7:5];
            rm = i[2:0];
            ea = 9'(r[rn] + {{11{i[4]}}, i[4:0]});
            case (i[15:11])
                5'b11010: begin
                    v = {{8{i[7]}}, i[7:0]}; r[rn] = v; exp_wr.push_back({rn, v}); exp_cyc.push_back(5);
                end
                5'b11000: begin
                    v = r[rm]; r[rd] = v; exp_wr.push_back({rd, v}); exp_cyc.push_back(7);
                    exp_cnt[1]++; exp_cnt[2]++; exp_cnt[4]++;
                end
                5'b10100, 5'b10110: begin
                    v = (i[12:11] == 2'b00) ? r[rn] + r[rm] : (r[rn] & r[rm]);
                    r[rd] = v; exp_wr.push_back({rd, v}); exp_cyc.push_back(8);
                    exp_cnt[0]++; exp_cnt[1]++; exp_cnt[2]++;
                end
                5'b10111: begin
                    v = ~r[rm]; r[rd] = v; exp_wr.push_back({rd, v}); exp_cyc.push_back(7);
                    exp_cnt[1]++; exp_cnt[2]++;
                end
                5'b10101: begin
                    exp_cyc.push_back(7);
                    exp_cnt[0]++; exp_cnt[1]++; exp_cnt[3]++;
                end
                5'b01100: begin
                    v = m[ea]; r[rd] = v; exp_wr.push_back({rd, v}); exp_cyc.push_back(9);
                    exp_cnt[0]++; exp_cnt[2]++; exp_cnt[5]++; exp_cnt[6] += 2;
                end
                5'b10000: begin
                    m[ea] = r[rd]; exp_mw.push_back({ea, r[rd]}); exp_cyc.push_back(10);
                    exp_cnt[0]++; exp_cnt[1]++; exp_cnt[2] += 2; exp_cnt[4]++; exp_cnt[5]++;
                end
                5'b11100: done = 1;
                default: begin
                    done = 1; exp_ill = 1'b1;
                end
            endcase
        end
        exp_pc = p;
    endtask

    // Monitor: pops expectations whenever the DUT presents a fetch, register write or memory write.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                cyc_cnt++;
                act_cnt[0] += int'(loada);
                act_cnt[1] += int'(loadb);
                act_cnt[2] += int'(loadc);
                act_cnt[3] += int'(loads);
                act_cnt[4] += int'(asel);
                act_cnt[5] += int'(bsel);
                act_cnt[6] += int'(mem_cmd == 2'b01);
                act_cnt[7] += int'(load_ir);
                if (load_ir) begin
                    if (exp_fetch.size() == 0) fail_evt("fetch");
                    else chk("fetch_cmd_addr", 32'({mem_cmd, mem_addr}), 32'({2'b01, exp_fetch.pop_front()}));
                    if (last_fetch >= 0) begin
                        if (exp_cyc.size() == 0) fail_evt("instr_cycles");
                        else chk("instr_cycles", 32'(cyc_cnt - last_fetch), 32'(exp_cyc.pop_front()));
                    end
                    last_fetch = cyc_cnt;
                end
                if (write) begin
                    if (exp_wr.size() == 0) fail_evt("reg_write");
                    else chk("reg_write", 32'({rsel, wr_val}), 32'(exp_wr.pop_front()));
                end
                if (mem_cmd == 2'b10) begin
                    if (exp_mw.size() == 0) fail_evt("mem_write");
                    else chk("mem_write", 32'({mem_addr, datapath_out}), 32'(exp_mw.pop_front()));
                end
            end
        end
    end

    task automatic run_program(input string tag);
        logic       exp_ill;
        logic [8:0] exp_pc, hold_pc;
        int         bad;
        bit         done;
        build_model(exp_ill, exp_pc);
        reset   = 1'b1;
        do_load = 1'b1;
        @(negedge clk);
        chk({tag, ":rst_ctrl"}, 32'(ctrl_vec), 32'd0);
        chk({tag, ":rst_pc"}, 32'(pc), 32'd0);
        for (int k = 0; k < 8; k++) act_cnt[k] = 0;
        cyc_cnt    = 0;
        last_fetch = -1;
        reset      = 1'b0;
        do_load    = 1'b0;
        mon_en     = 1'b1;
        done       = 0;
        for (int c = 0; c < 3000 && !done; c++) begin
            @(negedge clk);
            if (halted) done = 1;
        end
        if (!done) fail_evt({tag, ":halt_timeout"});
        hold_pc = pc;
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (halted !== 1'b1 || mem_cmd !== 2'b00 || pc !== hold_pc) bad++;
        end
        mon_en = 1'b0;
        chk({tag, ":halt_hold_violations"}, 32'(bad), 32'd0);
        chk({tag, ":final_pc"}, 32'(pc), 32'(exp_pc));
        chk({tag, ":illegal"}, 32'(illegal), 32'(exp_ill));
        chk({tag, ":pending_fetch"}, 32'(exp_fetch.size()), 32'd0);
        chk({tag, ":pending_cycles"}, 32'(exp_cyc.size()), 32'd0);
        chk({tag, ":pending_reg_writes"}, 32'(exp_wr.size()), 32'd0);
        chk({tag, ":pending_mem_writes"}, 32'(exp_mw.size()), 32'd0);
        for (int k = 0; k < 8; k++) chk($sformatf("%s:ctrl_count_%0d", tag, k), 32'(act_cnt[k]), 32'(exp_cnt[k]));
    endtask

    task automatic gen_random(input bit end_illegal);
        int         a, kind, d;
        logic [4:0] code;
        for (int k = 0; k < 512; k++) img_mem[k] = 16'($urandom);
        for (int k = 0; k < 8; k++) img_rf[k] = 16'($urandom);
        a = 0;
        while (a < 55) begin
            kind = $urandom_range(0, 7);
            d    = $urandom_range(0, 6);
            case (kind)
                0: img_mem[a] = e_movi(d, $urandom_range(0, 255));
                1: img_mem[a] = e_mov(d, $urandom_range(0, 7));
                2: img_mem[a] = e_alu(0, d, $urandom_range(0, 7), $urandom_range(0, 7));
                3: img_mem[a] = e_alu(1, d, $urandom_range(0, 7), $urandom_range(0, 7));
                4: img_mem[a] = e_alu(2, d, $urandom_range(0, 7), $urandom_range(0, 7));
                5: img_mem[a] = e_alu(3, d, $urandom_range(0, 7), $urandom_range(0, 7));
                default: begin
                    // Base register points into 64..142 so data never overlaps the program.
                    img_mem[a] = e_movi(7, $urandom_range(80, 127));
                    a++;
                    img_mem[a] = (kind == 6) ? e_ldr(d, 7, $urandom_range(0, 31))
                                             : e_str($urandom_range(0, 7), 7, $urandom_range(0, 31));
                end
            endcase
            a++;
        end
        if (end_illegal) begin
            do code = 5'($urandom_range(0, 31)); while (is_legal(code));
            img_mem[a] = {code, 11'($urandom)};
        end else begin
            img_mem[a] = 16'hE000;
        end
    endtask

    task automatic load_and_start();
        reset   = 1'b1;
        do_load = 1'b1;
        @(negedge clk);
        reset   = 1'b0;
        do_load = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        reset   = 1'b1;
        do_load = 1'b0;
        mon_en  = 1'b0;
        b_reset = 1'b1;
        for (int k = 0; k < 16; k++) b_mem[k] = 16'h0000;
        b_mem[15] = e_ldr(0, 0, 0);
        b_mem[0]  = 16'hE000;
        repeat (2) @(negedge clk);

        // Directed program: MOVI, ADD, LDR/STR through address 24, then the other ALU forms.
        for (int k = 0; k < 512; k++) img_mem[k] = 16'h0000;
        for (int k = 0; k < 8; k++) img_rf[k] = 16'h0000;
        img_mem[0]   = e_movi(0, 5);
        img_mem[1]   = e_movi(1, 3);
        img_mem[2]   = e_alu(0, 2, 1, 0);
        img_mem[3]   = e_movi(5, 100);
        img_mem[4]   = e_ldr(3, 5, 0);
        img_mem[5]   = e_movi(1, 20);
        img_mem[6]   = e_str(3, 1, 4);
        img_mem[7]   = e_ldr(4, 1, 4);
        img_mem[8]   = e_alu(3, 6, 0, 2);
        img_mem[9]   = e_alu(1, 0, 1, 0);
        img_mem[10]  = e_mov(7, 4);
        img_mem[11]  = e_alu(2, 6, 2, 1);
        img_mem[12]  = 16'hE000;
        img_mem[100] = 16'h1234;
        run_program("directed");
        chk("directed:r2_add", 32'(rf[2]), 32'd8);
        chk("directed:r4_ldr", 32'(rf[4]), 32'h1234);
        chk("directed:mem24", 32'(mem[24]), 32'h1234);

        // Illegal encoding {000,00} traps.
        for (int k = 0; k < 512; k++) img_mem[k] = 16'h0000;
        img_mem[0] = e_movi(0, 1);
        img_mem[1] = 16'h0000;
        run_program("trap");

        for (int t = 0; t < 4; t++) begin
            gen_random(t == 3);
            run_program($sformatf("random%0d", t));
        end

        // Reset during STB: no write, next cycle is RST.
        for (int k = 0; k < 512; k++) img_mem[k] = 16'h0000;
        img_mem[0]  = e_movi(1, 20);
        img_mem[1]  = e_str(1, 1, 4);
        img_mem[2]  = 16'hE000;
        img_mem[24] = 16'hBEEF;
        load_and_start();
        found = 0;
        for (int c = 0; c < 50 && !found; c++) begin
            if (nsel == 2'b01 && loadb) found = 1;
            else @(negedge clk);
        end
        if (!found) fail_evt("reset_stb:timeout");
        reset = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("reset_stb:ctrl", 32'(ctrl_vec), 32'd0);
        end
        chk("reset_stb:pc", 32'(pc), 32'd0);
        chk("reset_stb:mem24", 32'(mem[24]), 32'hBEEF);

        // Reset during LDW: write drops at that edge.
        img_mem[1] = e_ldr(2, 1, 4);
        load_and_start();
        found = 0;
        for (int c = 0; c < 50 && !found; c++) begin
            if (write && vsel == 2'b11) found = 1;
            else @(negedge clk);
        end
        if (!found) fail_evt("reset_ldw:timeout");
        reset = 1'b1;
        @(negedge clk);
        chk("reset_ldw:write", 32'(write), 32'd0);
        chk("reset_ldw:ctrl", 32'(ctrl_vec), 32'd0);

        // Narrow PC: fetch at 15, wrap to 0, LDR address truncated to 3.
        chk("narrow:rst_pc", 32'(b_pc), 32'd15);
        b_reset = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            case (c)
                1:  chk("narrow:if1_fetch", 32'({b_mem_cmd, b_mem_addr}), 32'({2'b01, 4'd15}));
                3:  chk("narrow:upc_pc", 32'(b_pc), 32'd15);
                4:  chk("narrow:wrapped_pc", 32'(b_pc), 32'd0);
                8:  chk("narrow:ldm_addr", 32'({b_mem_cmd, b_mem_addr}), 32'({2'b01, 4'd3}));
                9:  chk("narrow:ldw_addr", 32'({b_mem_cmd, b_mem_addr, b_write}), 32'({2'b01, 4'd3, 1'b1}));
                10: chk("narrow:next_fetch", 32'({b_mem_cmd, b_mem_addr}), 32'({2'b01, 4'd0}));
                default: ;
            endcase
        end
        found = 0;
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge clk);
            if (b_halted) found = 1;
        end
        chk("narrow:halted", 32'({b_halted, b_illegal}), 32'({1'b1, 1'b0}));
        chk("narrow:halt_pc", 32'(b_pc), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
